sdram_avalon_tester: RTL and testbench

- Avalon-MM initiator that drives the SDRAM controller's slave port: chipselect, write_n, read_n, byteenable_n, address, write_data, wait_request, read_data, data_validation.
- On start it writes a deterministic pattern over NUM_WORDS consecutive 16-bit words from a latched base address, then reads them back with pipelined reads.
- Every returned word is compared against the pattern and mismatches are counted.
- Used as the lab's on-board memory self-test, in place of a Nios master.

---
 rtl/sdram_avalon_tester.sv | 132 +++++++++++++
 tb/tb_sdram_avalon_tester.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_avalon_tester.sv
// sdram_avalon_tester: write/read-back self-test initiator for the SDRAM controller's Avalon-MM slave port.
// Define TESTER_LFSR_PATTERN_EN to use a 16-bit Fibonacci LFSR data pattern instead of (base+i) XOR SEED.
module sdram_avalon_tester #(
    parameter int          NUM_WORDS   = 1024,
    parameter int          MAX_PENDING = 4,
    parameter logic [15:0] SEED        = 16'hA5C3,
    parameter int          TIMEOUT     = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [24:0] base_addr,
    output logic        chipselect,
    output logic        write_n,
    output logic        read_n,
    output logic [1:0]  byteenable_n,
    output logic [24:0] address,
    output logic [15:0] write_data,
    input  logic [15:0] read_data,
    input  logic        wait_request,
    input  logic        data_validation,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] error_count,
    output logic [24:0] first_err_addr
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    localparam logic [15:0] LAST     = 16'(NUM_WORDS - 1);
    localparam logic [15:0] TOTAL    = 16'(NUM_WORDS);
    localparam logic [31:0] IDLE_MAX = 32'(TIMEOUT - 1);
    state_t      state, state_nxt;
    logic [24:0] base, base_nxt;
    logic [15:0] wr_idx, wr_idx_nxt, rd_idx, rd_idx_nxt, rx_idx;
    logic [3:0]  pending, pend_nxt;
    logic [31:0] idle_cnt;
    logic [15:0] wr_pat, rx_pat;
    logic        launch, reading, wr_acc, rd_acc, rx_ok, rx_bad, abort, wr_req, rd_req;

    assign launch     = start && (state == IDLE || state == DONE);
    assign reading    = state == READ || state == DRAIN;
    assign wr_acc     = chipselect && !write_n && !wait_request;
    assign rd_acc     = chipselect && !read_n && !wait_request;
    assign rx_ok      = data_validation && reading && rx_idx != TOTAL;
    assign rx_bad     = rx_ok && read_data != rx_pat;
    // idle_cnt holds the number of cycles since the last return (or READ entry)
    assign abort      = reading && !rx_ok && idle_cnt >= IDLE_MAX;
    assign base_nxt   = launch ? base_addr : base;
    assign wr_idx_nxt = launch ? 16'd0 : wr_idx + {15'd0, wr_acc};
    assign rd_idx_nxt = rd_idx + {15'd0, rd_acc};
    assign pend_nxt   = pending + {3'd0, rd_acc} - {3'd0, rx_ok && pending != 4'd0};
    assign busy       = state == WRITE || reading;
    assign done       = state == DONE;
    assign pass       = done && error_count == 16'd0 && !timeout;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? WRITE : state;
            WRITE:      state_nxt = (wr_acc && wr_idx == LAST) ? READ : WRITE;
            READ:       state_nxt = abort ? DONE : (rd_acc && rd_idx == LAST) ? DRAIN : READ;
            DRAIN:      state_nxt = (abort || (rx_ok && rx_idx == LAST)) ? DONE : DRAIN;
            default:    state_nxt = IDLE;
        endcase
        wr_req = state_nxt == WRITE;
        // bus idles for the first READ cycle; a stalled read stays asserted since pending cannot grow
        rd_req = state == READ && state_nxt == READ && pend_nxt < 4'(MAX_PENDING);
    end

`ifdef TESTER_LFSR_PATTERN_EN
    logic [15:0] lfsr_w, lfsr_r;
    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
    assign wr_pat = launch ? SEED : wr_acc ? step(lfsr_w) : lfsr_w;
    assign rx_pat = lfsr_r;
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_w <= SEED;
            lfsr_r <= SEED;
        end else begin
            lfsr_w <= wr_pat;
            lfsr_r <= (state == WRITE && state_nxt == READ) ? SEED : rx_ok ? step(lfsr_r) : lfsr_r;
        end
    end
`else
    assign wr_pat = (base_nxt[15:0] + wr_idx_nxt) ^ SEED;
    assign rx_pat = (base[15:0] + rx_idx) ^ SEED;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base           <= '0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            rx_idx         <= '0;
            pending        <= '0;
            idle_cnt       <= '0;
            chipselect     <= 1'b0;
            write_n        <= 1'b1;
            read_n         <= 1'b1;
            byteenable_n   <= 2'b11;
            address        <= '0;
            write_data     <= '0;
            timeout        <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
        end else begin
            base           <= base_nxt;
            wr_idx         <= wr_idx_nxt;
            rd_idx         <= launch ? '0 : rd_idx_nxt;
            rx_idx         <= launch ? '0 : rx_idx + {15'd0, rx_ok};
            pending        <= launch ? '0 : pend_nxt;
            idle_cnt       <= (reading && !rx_ok) ? idle_cnt + 32'd1 : 32'd1;
            chipselect     <= wr_req || rd_req;
            write_n        <= !wr_req;
            read_n         <= !rd_req;
            byteenable_n   <= (wr_req || rd_req) ? 2'b00 : 2'b11;
            address        <= wr_req ? base_nxt + {9'd0, wr_idx_nxt} : rd_req ? base + {9'd0, rd_idx_nxt} : address;
            write_data     <= wr_req ? wr_pat : write_data;
            timeout        <= !launch && (timeout || abort);
            error_count    <= launch ? '0 : (rx_bad && error_count != 16'hFFFF) ? error_count + 16'd1 : error_count;
            first_err_addr <= launch ? '0 : (rx_bad && error_count == 16'd0) ? base + {9'd0, rx_idx} : first_err_addr;
        end
    end
endmodule

// File: tb/tb_sdram_avalon_tester.sv
// tb_sdram_avalon_tester: directed test of sdram_avalon_tester against a behavioural Avalon slave
// with latency-2 reads, optional stalls, single-word corruption and dropped read returns.
module tb_sdram_avalon_tester;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [24:0] base_addr = '0;
    logic        chipselect, write_n, read_n, busy, done, pass, timeout;
    logic [1:0]  byteenable_n;
    logic [24:0] address, first_err_addr;
    logic [15:0] write_data, error_count;
    logic [15:0] read_data = '0;
    logic        wait_request = 1'b0, data_validation = 1'b0;

    sdram_avalon_tester #(.NUM_WORDS(8), .MAX_PENDING(4), .SEED(16'hA5C3), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .chipselect(chipselect), .write_n(write_n), .read_n(read_n), .byteenable_n(byteenable_n),
        .address(address), .write_data(write_data), .read_data(read_data),
        .wait_request(wait_request), .data_validation(data_validation),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .error_count(error_count), .first_err_addr(first_err_addr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {int due; logic [15:0] data;} ret_t;
    int          n_checks = 0, n_fail = 0;
    bit          stall_en = 0, bad_en = 0;
    logic [24:0] bad_addr = '0;
    int          ret_limit = 1000, n_req = 0, n_rd = 0, n_ret = 0, held = 0, n_stall = 0;
    int          max_out = 0, last_dv_cyc = 0, dc = 0;
    logic [24:0] h_addr;
    logic [15:0] h_data;
    logic        h_wn;
    bit   [15:0] mem [bit [24:0]];
    logic [24:0] wa[$], ra[$];
    logic [15:0] wd[$];
    int          wc[$];
    ret_t        rq[$];
    ret_t        r;
    logic [24:0] ea[8];
    logic [15:0] ed[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: reacts to the bus of the current cycle on the falling edge
    always @(negedge clock) begin
        data_validation = 1'b0;
        if (rq.size() != 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            if (n_ret < ret_limit) begin
                data_validation = 1'b1;
                read_data = r.data;
                n_ret++;
                last_dv_cyc = cyc;
            end
        end
        wait_request = 1'b0;
        if (chipselect === 1'b1 && (write_n === 1'b0 || read_n === 1'b0)) begin
            if (held > 0) begin
                chk("hold_addr", 32'(address), 32'(h_addr));
                chk("hold_data", 32'(write_data), 32'(h_data));
                chk("hold_wn", 32'(write_n), 32'(h_wn));
            end
            if (stall_en && (n_req % 2 == 1) && held < 3) begin
                if (held == 0) begin
                    h_addr = address;
                    h_data = write_data;
                    h_wn = write_n;
                end
                wait_request = 1'b1;
                held++;
                n_stall++;
            end else begin
                held = 0;
                n_req++;
                if (!write_n) begin
                    mem[address] = write_data;
                    wa.push_back(address);
                    wd.push_back(write_data);
                    wc.push_back(cyc);
                end else begin
                    ra.push_back(address);
                    rq.push_back('{cyc + 2, mem[address] ^ ((bad_en && address == bad_addr) ? 16'h0001 : 16'h0000)});
                    n_rd++;
                end
            end
        end
        if (n_rd - n_ret > max_out) max_out = n_rd - n_ret;
    end

    task automatic kick(input logic [24:0] b, input bit st, input int lim, input bit be, input logic [24:0] ba);
        @(posedge clock); #1;
        stall_en = st; ret_limit = lim; bad_en = be; bad_addr = ba;
        n_req = 0; n_rd = 0; n_ret = 0; held = 0; n_stall = 0; max_out = 0; last_dv_cyc = 0;
        wa.delete(); wd.delete(); ra.delete(); wc.delete(); rq.delete();
        base_addr = b;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(posedge clock); #1;
            k++;
        end
        chk("done_reached", 32'(done), 1);
        dc = cyc;
    endtask

    task automatic check_log(input string t);
        chk({t, "_nwr"}, wa.size(), 8);
        chk({t, "_nrd"}, ra.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_wa%0d", t, i), 32'(wa[i]), 32'(ea[i]));
            chk($sformatf("%s_wd%0d", t, i), 32'(wd[i]), 32'(ed[i]));
            chk($sformatf("%s_ra%0d", t, i), 32'(ra[i]), 32'(ea[i]));
        end
    endtask

    task automatic reset_vals(input string t);
        chk({t, "_cs"}, 32'(chipselect), 0);
        chk({t, "_wn"}, 32'(write_n), 1);
        chk({t, "_rn"}, 32'(read_n), 1);
        chk({t, "_be"}, 32'(byteenable_n), 3);
        chk({t, "_addr"}, 32'(address), 0);
        chk({t, "_wd"}, 32'(write_data), 0);
        chk({t, "_busy"}, 32'(busy), 0);
        chk({t, "_done"}, 32'(done), 0);
        chk({t, "_pass"}, 32'(pass), 0);
        chk({t, "_tmo"}, 32'(timeout), 0);
        chk({t, "_err"}, 32'(error_count), 0);
        chk({t, "_ferr"}, 32'(first_err_addr), 0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clock);
        #1;
        reset_vals("rst");
        reset = 1'b0;

        // 1: zero-wait slave, base 0
        kick(25'h0, 0, 1000, 0, 25'h0);
        chk("t1_cs", 32'(chipselect), 1);
        chk("t1_wn", 32'(write_n), 0);
        chk("t1_rn", 32'(read_n), 1);
        chk("t1_be", 32'(byteenable_n), 0);
        chk("t1_addr0", 32'(address), 0);
        chk("t1_wd0", 32'(write_data), 32'hA5C3);
        chk("t1_busy", 32'(busy), 1);
        wait_done();
        chk("t1_latency", dc - last_dv_cyc, 1);
        chk("t1_b2b", wc[7] - wc[0], 7);
        ea = '{25'h0, 25'h1, 25'h2, 25'h3, 25'h4, 25'h5, 25'h6, 25'h7};
        ed = '{16'hA5C3, 16'hA5C2, 16'hA5C1, 16'hA5C0, 16'hA5C7, 16'hA5C6, 16'hA5C5, 16'hA5C4};
        check_log("t1");
        chk("t1_pass", 32'(pass), 1);
        chk("t1_err", 32'(error_count), 0);
        chk("t1_ferr", 32'(first_err_addr), 0);
        chk("t1_tmo", 32'(timeout), 0);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_cs_end", 32'(chipselect), 0);
        chk("t1_maxpend", 32'(max_out <= 4), 1);

        // 2: every second request stalled for 3 cycles
        kick(25'h40, 1, 1000, 0, 25'h0);
        wait_done();
        ea = '{25'h40, 25'h41, 25'h42, 25'h43, 25'h44, 25'h45, 25'h46, 25'h47};
        ed = '{16'hA583, 16'hA582, 16'hA581, 16'hA580, 16'hA587, 16'hA586, 16'hA585, 16'hA584};
        check_log("t2");
        chk("t2_stalls", n_stall, 24);
        chk("t2_pass", 32'(pass), 1);
        chk("t2_maxpend", 32'(max_out <= 4), 1);

        // 3: word 5 returned with bit 0 flipped
        kick(25'h100, 0, 1000, 1, 25'h105);
        wait_done();
        ea = '{25'h100, 25'h101, 25'h102, 25'h103, 25'h104, 25'h105, 25'h106, 25'h107};
        ed = '{16'hA4C3, 16'hA4C2, 16'hA4C1, 16'hA4C0, 16'hA4C7, 16'hA4C6, 16'hA4C5, 16'hA4C4};
        check_log("t3");
        chk("t3_err", 32'(error_count), 1);
        chk("t3_ferr", 32'(first_err_addr), 32'h105);
        chk("t3_pass", 32'(pass), 0);
        chk("t3_tmo", 32'(timeout), 0);

        // 4: address wrap; a start pulse mid-write must be ignored
        kick(25'h1FFFFFE, 0, 1000, 0, 25'h0);
        base_addr = 25'h55;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done();
        ea = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0, 25'h1, 25'h2, 25'h3, 25'h4, 25'h5};
        ed = '{16'h5A3D, 16'h5A3C, 16'hA5C3, 16'hA5C2, 16'hA5C1, 16'hA5C0, 16'hA5C7, 16'hA5C6};
        check_log("t4");
        chk("t4_pass", 32'(pass), 1);

        // 5: only 3 reads returned, abort after TIMEOUT=16
        kick(25'h0, 0, 3, 0, 25'h0);
        wait_done();
        chk("t5_tmo", 32'(timeout), 1);
        chk("t5_pass", 32'(pass), 0);
        chk("t5_tmo_delay", dc - last_dv_cyc, 16);
        chk("t5_maxpend", max_out, 4);
        chk("t5_nrd", n_rd, 7);
        chk("t5_nret", n_ret, 3);
        chk("t5_err", 32'(error_count), 0);
        chk("t5_cs", 32'(chipselect), 0);

        // 6: reset with two reads outstanding, then a clean run
        kick(25'h0, 0, 1000, 0, 25'h0);
        k = 0;
        while (!(wa.size() == 8 && n_rd - n_ret == 2) && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        chk("t6_reach", 32'(k < 100), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset_vals("t6rst");
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("t6_ign_err", 32'(error_count), 0);
        chk("t6_ign_busy", 32'(busy), 0);
        chk("t6_ign_done", 32'(done), 0);
        kick(25'h0, 0, 1000, 0, 25'h0);
        wait_done();
        ea = '{25'h0, 25'h1, 25'h2, 25'h3, 25'h4, 25'h5, 25'h6, 25'h7};
        ed = '{16'hA5C3, 16'hA5C2, 16'hA5C1, 16'hA5C0, 16'hA5C7, 16'hA5C6, 16'hA5C5, 16'hA5C4};
        check_log("t6");
        chk("t6_pass", 32'(pass), 1);
        chk("t6_tmo", 32'(timeout), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
